spsram_arbiter: RTL and testbench
=================================

Name: spsram_arbiter

Overview:
- Two-requester round-robin arbiter and sequencer for a single-port synchronous SRAM (ports i_data/i_addr/i_wen/i_cen/i_oen/o_data).
- Accepts one read or write per cycle from requester A or B and drives the SRAM command from registers.
- Returns read data to the owning requester with a fixed 3-cycle latency.
- Sits between two datapath masters (e.g. DMA and CPU-side logic) and one SRAM macro.

Parameters:
- BW_DATA, 32, data width of SRAM and requester data buses.
- BW_ADDR, 5, SRAM address width.

Ports:
- i_clk  in  1  clock; all logic on the rising edge.
- i_rst  in  1  reset, synchronous, active-high.
- i_a_req  in  1  requester A command valid.
- i_a_wen  in  1  A: 1=write, 0=read.
- i_a_addr  in  BW_ADDR  A address.
- i_a_data  in  BW_DATA  A write data.
- o_a_gnt  out  1  A command accepted this cycle (combinational).
- o_a_rvalid  out  1  A read data valid, one-cycle pulse.
- o_a_rdata  out  BW_DATA  A read data.
- i_b_req, i_b_wen, i_b_addr, i_b_data, o_b_gnt, o_b_rvalid, o_b_rdata: same as A, for requester B.
- o_mem_data  out  BW_DATA  SRAM write data.
- o_mem_addr  out  BW_ADDR  SRAM address.
- o_mem_wen  out  1  SRAM write enable.
- o_mem_cen  out  1  SRAM chip enable.
- o_mem_oen  out  1  SRAM output enable.
- i_mem_data  in  BW_DATA  SRAM read data; valid the cycle after a read command is presented.

Behaviour:
- Reset (i_rst=1 at an edge):
  - Clears all mem outputs, rvalid, rdata and the pipeline tags to 0.
  - Sets the priority pointer to A.
  - o_x_gnt=0 while i_rst=1.
- Handshake: a requester holds req and its fields stable until gnt. Fields are sampled in the cycle gnt=1. Dropping req before gnt is allowed.
- Arbitration (combinational, cycle T):
  - Only one requester asserting req: it is granted.
  - Both asserting req: the pointer owner is granted.
  - After any grant, the pointer moves to the non-granted requester.
  - Neither asserting req: no grant, pointer unchanged.
  - At most one gnt per cycle; full throughput of one command per cycle.
- Command stage (registered, cycle T+1):
  - o_mem_cen=1, o_mem_wen=wen, o_mem_oen=~wen, address/data from the granted requester.
  - No grant at T: cen=wen=oen=0 at T+1. addr/data hold their previous values.
- Tag pipeline:
  - Stage 1 registers {valid_read, owner} alongside the command.
  - Stage 2 registers it again at T+2, while i_mem_data is valid.
- Response (registered, cycle T+3): o_owner_rvalid=1 and o_owner_rdata=i_mem_data captured at T+2. The other requester's rvalid stays 0.
- rdata holds its last value when rvalid=0.
- Writes produce no response.
- Read latency is exactly 3 cycles from gnt to rvalid. Responses are in order. Back-to-back reads yield back-to-back rvalids.
- Read-after-write to the same address granted in consecutive cycles returns the new data; the SRAM is written at the end of T+1, before the read command at T+2.
- Reset mid-operation: in-flight reads are dropped and no rvalid follows. The first grant after reset goes to A if both request.
- The block holds no FSM beyond the pointer bit and the two tag stages; no buffering, so requester backpressure is via gnt only.

Decomposition:
- Shared package (or include):
  - BW_DATA/BW_ADDR defaults.
  - Owner encoding constants: OWNER_A=0, OWNER_B=1.
  - Latency constant RD_LAT=3.
- One natural sub-module: spsram_rr_arb2, the combinational 2-way round-robin grant plus pointer register.
- The top holds the command registers, tag pipeline and response registers.

Test Plan:
- Reset then idle: no req for 10 cycles -> all gnt/rvalid=0, mem cen=wen=oen=0.
- A writes addr 0..31 data=addr (A only) -> gnt every cycle; mem cen=1, wen=1, addr k one cycle after grant k.
- Both hold req, A reads addr 3, B reads addr 7 after the write fill -> grants alternate A,B,A,B starting with A; a_rvalid returns 3 and b_rvalid returns 7, each 3 cycles after its grant; the other requester's rvalid stays 0.
- A write addr 5 = 0xDEADBEEF, then B read addr 5 the next cycle -> b_rdata=0xDEADBEEF at grant+3.
- 8 back-to-back A reads of addr 0..7 -> a_rvalid high 8 consecutive cycles, data 0..7 in order.
- Assert i_rst one cycle after granting an A read of addr 2 -> no a_rvalid ever for that read; mem outputs 0; with both requesting after reset, A is granted first.

Source files
------------

// File: rtl/spsram_arbiter_pkg.sv
// Shared constants and types for the two-requester single-port SRAM arbiter.
package spsram_arbiter_pkg;

    localparam int BW_DATA_DEF = 32;
    localparam int BW_ADDR_DEF = 5;

    localparam logic OWNER_A = 1'b0;
    localparam logic OWNER_B = 1'b1;

    // Cycles from grant to read-data valid at the requester.
    localparam int RD_LAT = 3;

    typedef struct packed {
        logic rd;
        logic owner;
    } tag_t;

endpackage

// File: rtl/spsram_rr_arb2.sv
// Two-way round-robin grant with a single pointer bit naming the preferred requester.
module spsram_rr_arb2
    import spsram_arbiter_pkg::*;
(
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_a_req,
    input  logic i_b_req,
    output logic o_a_gnt,
    output logic o_b_gnt
);

    logic r_ptr;

    assign o_a_gnt = ~i_rst & i_a_req & (~i_b_req | (r_ptr == OWNER_A));
    assign o_b_gnt = ~i_rst & i_b_req & (~i_a_req | (r_ptr == OWNER_B));

    // After a grant the pointer moves to whoever was not granted.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_ptr <= OWNER_A;
        end else if (o_a_gnt) begin
            r_ptr <= OWNER_B;
        end else if (o_b_gnt) begin
            r_ptr <= OWNER_A;
        end
    end

endmodule

// File: rtl/spsram_arbiter.sv
// Round-robin sequencer for one single-port SRAM shared by requesters A and B;
// registered SRAM command plus a two-stage tag pipeline routing read data back.
module spsram_arbiter
    import spsram_arbiter_pkg::*;
#(
    parameter int BW_DATA = BW_DATA_DEF,
    parameter int BW_ADDR = BW_ADDR_DEF
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_a_req,
    input  logic               i_a_wen,
    input  logic [BW_ADDR-1:0] i_a_addr,
    input  logic [BW_DATA-1:0] i_a_data,
    output logic               o_a_gnt,
    output logic               o_a_rvalid,
    output logic [BW_DATA-1:0] o_a_rdata,
    input  logic               i_b_req,
    input  logic               i_b_wen,
    input  logic [BW_ADDR-1:0] i_b_addr,
    input  logic [BW_DATA-1:0] i_b_data,
    output logic               o_b_gnt,
    output logic               o_b_rvalid,
    output logic [BW_DATA-1:0] o_b_rdata,
    output logic [BW_DATA-1:0] o_mem_data,
    output logic [BW_ADDR-1:0] o_mem_addr,
    output logic               o_mem_wen,
    output logic               o_mem_cen,
    output logic               o_mem_oen,
    input  logic [BW_DATA-1:0] i_mem_data
);

    logic               w_a_gnt, w_b_gnt, w_gnt, w_wen;
    logic [BW_ADDR-1:0] w_addr;
    logic [BW_DATA-1:0] w_data;

    logic               r_cen, r_wen, r_oen;
    logic [BW_ADDR-1:0] r_addr;
    logic [BW_DATA-1:0] r_data;
    tag_t               r_tag1, r_tag2;
    logic               r_a_rvalid, r_b_rvalid;
    logic [BW_DATA-1:0] r_a_rdata, r_b_rdata;

    spsram_rr_arb2 u_arb (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_a_req (i_a_req),
        .i_b_req (i_b_req),
        .o_a_gnt (w_a_gnt),
        .o_b_gnt (w_b_gnt)
    );

    assign w_gnt  = w_a_gnt | w_b_gnt;
    assign w_wen  = w_b_gnt ? i_b_wen  : i_a_wen;
    assign w_addr = w_b_gnt ? i_b_addr : i_a_addr;
    assign w_data = w_b_gnt ? i_b_data : i_a_data;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_cen      <= 1'b0;
            r_wen      <= 1'b0;
            r_oen      <= 1'b0;
            r_addr     <= '0;
            r_data     <= '0;
            r_tag1     <= '0;
            r_tag2     <= '0;
            r_a_rvalid <= 1'b0;
            r_b_rvalid <= 1'b0;
            r_a_rdata  <= '0;
            r_b_rdata  <= '0;
        end else begin
            r_cen <= w_gnt;
            r_wen <= w_gnt & w_wen;
            r_oen <= w_gnt & ~w_wen;
            if (w_gnt) begin
                r_addr <= w_addr;
                r_data <= w_data;
            end
            r_tag1.rd    <= w_gnt & ~w_wen;
            r_tag1.owner <= w_b_gnt ? OWNER_B : OWNER_A;
            // Stage 2 lines up with i_mem_data from the stage-1 command.
            r_tag2     <= r_tag1;
            r_a_rvalid <= r_tag2.rd & (r_tag2.owner == OWNER_A);
            r_b_rvalid <= r_tag2.rd & (r_tag2.owner == OWNER_B);
            if (r_tag2.rd && r_tag2.owner == OWNER_A) r_a_rdata <= i_mem_data;
            if (r_tag2.rd && r_tag2.owner == OWNER_B) r_b_rdata <= i_mem_data;
        end
    end

    assign o_a_gnt    = w_a_gnt;
    assign o_b_gnt    = w_b_gnt;
    assign o_mem_cen  = r_cen;
    assign o_mem_wen  = r_wen;
    assign o_mem_oen  = r_oen;
    assign o_mem_addr = r_addr;
    assign o_mem_data = r_data;
    assign o_a_rvalid = r_a_rvalid;
    assign o_b_rvalid = r_b_rvalid;
    assign o_a_rdata  = r_a_rdata;
    assign o_b_rdata  = r_b_rdata;

endmodule

// File: tb/tb_spsram_arbiter.sv
// Directed + random bench for spsram_arbiter with a behavioural SRAM and a
// cycle-indexed reference model of grants, SRAM commands and read responses.
module tb_spsram_arbiter;

    logic        i_clk = 1'b0;
    logic        i_rst;
    logic        i_a_req, i_a_wen, i_b_req, i_b_wen;
    logic [4:0]  i_a_addr, i_b_addr;
    logic [31:0] i_a_data, i_b_data;
    logic        o_a_gnt, o_a_rvalid, o_b_gnt, o_b_rvalid;
    logic [31:0] o_a_rdata, o_b_rdata;
    logic [31:0] o_mem_data;
    logic [4:0]  o_mem_addr;
    logic        o_mem_wen, o_mem_cen, o_mem_oen;
    logic [31:0] i_mem_data;

    always #5 i_clk = ~i_clk;

    spsram_arbiter #(.BW_DATA(32), .BW_ADDR(5)) dut (
        .i_clk(i_clk), .i_rst(i_rst),
        .i_a_req(i_a_req), .i_a_wen(i_a_wen), .i_a_addr(i_a_addr), .i_a_data(i_a_data),
        .o_a_gnt(o_a_gnt), .o_a_rvalid(o_a_rvalid), .o_a_rdata(o_a_rdata),
        .i_b_req(i_b_req), .i_b_wen(i_b_wen), .i_b_addr(i_b_addr), .i_b_data(i_b_data),
        .o_b_gnt(o_b_gnt), .o_b_rvalid(o_b_rvalid), .o_b_rdata(o_b_rdata),
        .o_mem_data(o_mem_data), .o_mem_addr(o_mem_addr), .o_mem_wen(o_mem_wen),
        .o_mem_cen(o_mem_cen), .o_mem_oen(o_mem_oen), .i_mem_data(i_mem_data)
    );

    // Behavioural single-port SRAM: read data appears the cycle after the command.
    logic [31:0] sram [32];
    always @(posedge i_clk) begin
        if (o_mem_cen) begin
            if (o_mem_wen) sram[o_mem_addr] <= o_mem_data;
            else           i_mem_data <= sram[o_mem_addr];
        end
    end

    // Reference model state
    int          errors = 0;
    int          checks = 0;
    int          cyc    = 0;
    logic [31:0] mmem [32];
    bit          ptr_b;
    bit          sv_a [1024];
    bit          sv_b [1024];
    logic [31:0] sd_a [1024];
    logic [31:0] sd_b [1024];
    logic        e_cen, e_wen, e_oen;
    logic [4:0]  e_addr;
    logic [31:0] e_data, e_rda, e_rdb;
    bit          mg_a, mg_b;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, obs, exp);
        end
    endtask

    task automatic step(input bit rst,
                        input bit ar, input bit aw, input logic [4:0] aa, input logic [31:0] ad,
                        input bit br, input bit bw, input logic [4:0] ba, input logic [31:0] bd);
        bit          ga, gb, w;
        logic [4:0]  ca;
        logic [31:0] cd;
        i_rst = rst;
        i_a_req = ar; i_a_wen = aw; i_a_addr = aa; i_a_data = ad;
        i_b_req = br; i_b_wen = bw; i_b_addr = ba; i_b_data = bd;
        @(negedge i_clk);
        if (sv_a[cyc]) e_rda = sd_a[cyc];
        if (sv_b[cyc]) e_rdb = sd_b[cyc];
        chk("mem_cen",  32'(o_mem_cen),  32'(e_cen));
        chk("mem_wen",  32'(o_mem_wen),  32'(e_wen));
        chk("mem_oen",  32'(o_mem_oen),  32'(e_oen));
        chk("mem_addr", 32'(o_mem_addr), 32'(e_addr));
        chk("mem_data", o_mem_data, e_data);
        chk("a_rvalid", 32'(o_a_rvalid), 32'(sv_a[cyc]));
        chk("b_rvalid", 32'(o_b_rvalid), 32'(sv_b[cyc]));
        chk("a_rdata",  o_a_rdata, e_rda);
        chk("b_rdata",  o_b_rdata, e_rdb);
        // Grant rules: lone requester wins; on contention the pointer owner wins.
        ga = !rst && ar && (!br || !ptr_b);
        gb = !rst && br && (!ar ||  ptr_b);
        chk("a_gnt", 32'(o_a_gnt), 32'(ga));
        chk("b_gnt", 32'(o_b_gnt), 32'(gb));
        mg_a = ga; mg_b = gb;
        if (rst) begin
            e_cen = 0; e_wen = 0; e_oen = 0; e_addr = '0; e_data = '0;
            e_rda = '0; e_rdb = '0; ptr_b = 0;
            for (int k = 1; k <= 3; k++) begin sv_a[cyc+k] = 0; sv_b[cyc+k] = 0; end
        end else if (ga || gb) begin
            w  = ga ? aw : bw;
            ca = ga ? aa : ba;
            cd = ga ? ad : bd;
            e_cen = 1; e_wen = w; e_oen = !w; e_addr = ca; e_data = cd;
            if (w) mmem[ca] = cd;
            else if (ga) begin sv_a[cyc+3] = 1; sd_a[cyc+3] = mmem[ca]; end
            else         begin sv_b[cyc+3] = 1; sd_b[cyc+3] = mmem[ca]; end
            ptr_b = ga;
        end else begin
            e_cen = 0; e_wen = 0; e_oen = 0;
        end
        @(posedge i_clk); #1;
        cyc++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    bit          pa, paw, pb, pbw;
    logic [4:0]  paa, pba;
    logic [31:0] pad, pbd;

    initial begin
        ptr_b = 0;
        e_cen = 0; e_wen = 0; e_oen = 0; e_addr = '0; e_data = '0; e_rda = '0; e_rdb = '0;
        i_rst = 1;
        i_a_req = 0; i_a_wen = 0; i_a_addr = '0; i_a_data = '0;
        i_b_req = 0; i_b_wen = 0; i_b_addr = '0; i_b_data = '0;
        @(posedge i_clk); #1;
        step(1, 0, 0, 0, 0, 0, 0, 0, 0);
        idle(10);
        // Fill: A writes data=addr
        for (int k = 0; k < 32; k++) step(0, 1, 1, 5'(k), 32'(k), 0, 0, 0, 0);
        idle(1);
        // Reset so the contention run starts from pointer=A
        step(1, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int k = 0; k < 6; k++) step(0, 1, 0, 5'd3, 0, 1, 0, 5'd7, 0);
        idle(4);
        for (int k = 0; k < 8; k++) step(0, 1, 0, 5'(k), 0, 0, 0, 0, 0);
        idle(4);
        // Read-after-write across requesters
        step(0, 1, 1, 5'd5, 32'hDEADBEEF, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 1, 0, 5'd5, 0);
        idle(4);
        // Reset with a read in flight
        step(0, 1, 0, 5'd2, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int k = 0; k < 3; k++) step(0, 1, 0, 5'd1, 0, 1, 0, 5'd4, 0);
        idle(5);
        // Random traffic with hold-until-grant handshake and occasional withdrawal
        pa = 0; pb = 0; paw = 0; pbw = 0; paa = '0; pba = '0; pad = '0; pbd = '0;
        for (int n = 0; n < 300; n++) begin
            if (!pa && $urandom_range(0, 2) != 0) begin
                pa = 1; paw = $urandom_range(0, 1) == 1; paa = 5'($urandom); pad = $urandom;
            end
            if (!pb && $urandom_range(0, 2) != 0) begin
                pb = 1; pbw = $urandom_range(0, 1) == 1; pba = 5'($urandom); pbd = $urandom;
            end
            step(($urandom_range(0, 99) == 0), pa, paw, paa, pad, pb, pbw, pba, pbd);
            if (mg_a || $urandom_range(0, 7) == 0) pa = 0;
            if (mg_b || $urandom_range(0, 7) == 0) pb = 0;
        end
        idle(5);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
